// File: rtl/reg_scoreboard.sv
// ---------------------------------------------------------------------------
// reg_scoreboard
//   Producer-side hazard tracker sitting at ID/issue of the 5-stage MIPS
//   pipeline. For every architectural register 1..31 it keeps a countdown of
//   the cycles left until that register's pending result reaches a stage the
//   forwarding network can read. An ID instruction whose sources are still
//   counting down is held (stall) until they become forwardable. A saturating
//   counter records how many cycles were lost to stalls.
//
// Ports:
//   clk_i          rising-edge clock
//   rst_n          asynchronous active-low reset
//   issue_valid    an instruction is present in ID
//   issue_regwrite instruction writes the register file
//   issue_memread  instruction is a load
//   issue_mul      instruction is a multi-cycle multiply (ignored for loads)
//   issue_regs     rs of the ID instruction
//   issue_regt     rt of the ID instruction
//   issue_uses_rt  rt is a true source operand
//   issue_regd     destination register of the ID instruction
//   flush          branch/jump squash of the ID instruction
//   stall          hold PC/IF-ID and bubble ID/EX (combinational)
//   busy_mask      bit r set while register r still has a pending countdown
//   stall_count    saturating count of stalled cycles
// ---------------------------------------------------------------------------
module reg_scoreboard #(
  parameter int LOAD_LAT    = 1,
  parameter int MUL_LAT     = 3,
  parameter int CNT_W       = 2,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_n,
  input  logic                   issue_valid,
  input  logic                   issue_regwrite,
  input  logic                   issue_memread,
  input  logic                   issue_mul,
  input  logic [4:0]             issue_regs,
  input  logic [4:0]             issue_regt,
  input  logic                   issue_uses_rt,
  input  logic [4:0]             issue_regd,
  input  logic                   flush,
  output logic                   stall,
  output logic [31:0]            busy_mask,
  output logic [STALL_CNT_W-1:0] stall_count
);

  // Register 0 is hard-wired to zero in MIPS, so it is never tracked.
  logic [31:1][CNT_W-1:0]   countdown_q, countdown_d;
  logic [STALL_CNT_W-1:0]   stall_count_q, stall_count_d;

  logic [31:0]              busyVec;
  logic                     hzS, hzT;
  logic                     issueEn;
  logic [CNT_W-1:0]         newLat;

  // Bit 0 of busyVec stays 0, which makes the "source is not $0" part of
  // the hazard check fall out of a plain index lookup.
  always_comb begin
    busyVec = '0;
    for (int r = 1; r < 32; r++) begin
      busyVec[r] = |countdown_q[r];
    end
  end

  assign hzS       = busyVec[issue_regs];
  assign hzT       = issue_uses_rt && busyVec[issue_regt];
  // Flush wins over stall: a squashed instruction never holds the front end.
  assign stall     = issue_valid && !flush && (hzS || hzT);
  assign busy_mask = busyVec;

  assign issueEn = issue_valid && !flush && !stall && issue_regwrite &&
                   (issue_regd != 5'd0);

  // ALU results forward the next cycle, so they record no wait at all.
  always_comb begin
    if (issue_memread) begin
      newLat = CNT_W'(LOAD_LAT);
    end else if (issue_mul) begin
      newLat = CNT_W'(MUL_LAT);
    end else begin
      newLat = '0;
    end
  end

  // Every countdown ticks toward zero each cycle, stalled or not; an issuing
  // writer keeps the longer of the remaining wait and its own latency so a
  // younger fast producer cannot hide an older slow one (WAW).
  always_comb begin
    countdown_d = '0;
    for (int r = 1; r < 32; r++) begin
      logic [CNT_W-1:0] dec;
      dec = (countdown_q[r] == '0) ? '0 : countdown_q[r] - 1'b1;
      if (issueEn && (issue_regd == r[4:0])) begin
        countdown_d[r] = (dec > newLat) ? dec : newLat;
      end else begin
        countdown_d[r] = dec;
      end
    end
  end

  // The performance counter sticks at all-ones instead of wrapping.
  always_comb begin
    stall_count_d = stall_count_q;
    if (stall && (stall_count_q != '1)) begin
      stall_count_d = stall_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      countdown_q   <= '0;
      stall_count_q <= '0;
    end else begin
      countdown_q   <= countdown_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign stall_count = stall_count_q;

endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
- Producer-side hazard tracker for the 5-stage MIPS pipeline. It sits at ID/issue and records, for each architectural register, how many cycles remain until that register's pending result can be forwarded.
- The operand forwarding logic consumes results only once they reach EX/MEM or MEM/WB. This block guarantees an instruction never issues before its sources are forwardable.
- Output is a stall that freezes PC/IF-ID and bubbles ID/EX, plus a saturating stall-cycle counter.

Parameters:
- LOAD_LAT, 1, extra cycles a load result needs before it is forwardable (load-use bubble count).
- MUL_LAT, 3, extra cycles a multi-cycle multiply result needs before it is forwardable.
- CNT_W, 2, width of each per-register countdown; must satisfy 2^CNT_W-1 >= max(LOAD_LAT, MUL_LAT).
- STALL_CNT_W, 16, width of the stall performance counter.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- issue_valid  input  1  an instruction is present in ID this cycle.
- issue_regwrite  input  1  the instruction writes the register file.
- issue_memread  input  1  the instruction is a load.
- issue_mul  input  1  the instruction is a multi-cycle multiply; ignored when issue_memread=1.
- issue_regs  input  5  rs of the ID instruction.
- issue_regt  input  5  rt of the ID instruction.
- issue_uses_rt  input  1  rt is a true source (0 for I-type ALU and loads).
- issue_regd  input  5  destination register of the ID instruction.
- flush  input  1  branch/jump squash of the ID instruction this cycle.
- stall  output  1  hold PC/IF-ID and insert a bubble into ID/EX.
- busy_mask  output  32  bit r = 1 when countdown[r] != 0; bit 0 is always 0.
- stall_count  output  STALL_CNT_W  number of cycles stall was asserted, saturating.

Behaviour:
- State: countdown[1..31], CNT_W bits each; register 0 is never tracked. Plus the stall_count register.
- Reset (rst_n=0, asynchronous): all countdowns = 0, stall_count = 0. Therefore stall = 0 and busy_mask = 0 immediately, with no clock required.
- Source hazards, combinational:
  - hz_s = (issue_regs != 0) && countdown[issue_regs] != 0.
  - hz_t = issue_uses_rt && (issue_regt != 0) && countdown[issue_regt] != 0.
- stall = issue_valid && !flush && (hz_s || hz_t). The output is purely combinational, so there is zero-cycle latency from inputs.
- "Issue" means issue_valid && !flush && !stall && issue_regwrite && issue_regd != 0.
- New latency for an issuing instruction:
  - LOAD_LAT if issue_memread.
  - Otherwise MUL_LAT if issue_mul.
  - Otherwise 0, because ALU results are forwardable next cycle and are not tracked.
- Per-register update each rising edge:
  - dec = (countdown[r] == 0) ? 0 : countdown[r] - 1.
  - If issue targets r: countdown[r] = max(dec, new latency). This is the WAW rule: the longest outstanding wait wins.
  - Otherwise: countdown[r] = dec.
- Decrement continues during stall cycles; this is how stalls resolve.
- Stalled or flushed instructions never modify countdowns.
- flush has priority over stall: a squashed instruction neither stalls nor records.
- Self-dependence: when a source equals issue_regd and is busy, the instruction stalls; the destination is recorded only on the issuing cycle.
- stall_count increments by 1 on each edge with stall=1. It holds at all-ones (no wrap) and is cleared only by reset.
- Reset mid-stall: stall drops asynchronously and all pending state is discarded.
- Implementation is 31 countdown registers plus a comparator/max per register.

Test Plan:
- Load-use: issue lw $8 (memread=1), then next cycle add $9,$8,$10 with uses_rt=1 -> stall=1 for exactly 1 cycle, busy_mask[8]=1 for 1 cycle, add issues on the 2nd cycle, stall_count=1.
- Multiply chain: issue mul $5 (issue_mul=1, MUL_LAT=3), then a consumer of $5 -> stall high 3 consecutive cycles, then 0; stall_count=3.
- Register 0 and non-source rt:
  - lw $0 followed by add using $0 -> no stall, busy_mask=0.
  - lw $4 followed by addi $6,$3,imm with regt=4, uses_rt=0 -> no stall.
- WAW max: mul $7 (countdown 3); next cycle lw $7 with independent sources -> countdown[7]=max(2,1)=2; a consumer of $7 issued next stalls 2 cycles.
- Flush priority: a consumer of a busy register presented with flush=1 -> stall=0, no countdown change, stall_count unchanged.
- Async reset mid-stall: during a MUL stall (cycle 1 of 3), drop rst_n between edges -> stall=0, busy_mask=0, stall_count=0 immediately; after release, the same consumer issues with no stall.
